// File: rtl/regfile_bist_pkg.sv
// Shared types and pattern helpers for the 32x32 register-file BIST sequencer.
package regfile_bist_pkg;

    localparam int BIST_XLEN = 32;
    localparam int BIST_AW   = 5;
    localparam logic [BIST_XLEN-1:0] PAT_BASE = 32'hA5A5_A500;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RD0,
        S_WR1,
        S_RD1,
        S_DONE,
        S_FAIL
    } bist_state_t;

    // Pattern 0 tags each word with its address; pattern 1 is its complement.
    function automatic logic [BIST_XLEN-1:0] bist_pattern(input logic pat,
                                                          input logic [BIST_AW-1:0] idx);
        logic [BIST_XLEN-1:0] p0;
        p0 = PAT_BASE | {{(BIST_XLEN-BIST_AW){1'b0}}, idx};
        return pat ? ~p0 : p0;
    endfunction

    function automatic logic [BIST_XLEN-1:0] bist_expect(input logic pat,
                                                         input logic [BIST_AW-1:0] idx);
        return (idx == '0) ? '0 : bist_pattern(pat, idx);
    endfunction

endpackage

// File: rtl/regfile_bist_ctrl.sv
// BIST sequencer: writes two complementary address-tagged patterns into the
// regfile and reads every entry back on both ports, reporting the first mismatch.
module regfile_bist_ctrl
    import regfile_bist_pkg::*;
#(
    parameter int XLEN = BIST_XLEN,
    parameter int AW   = BIST_AW
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic            o_fail,
    output logic [AW-1:0]   o_fail_addr,
    output logic [XLEN-1:0] o_fail_data,
    output logic            o_we3,
    output logic [AW-1:0]   o_a3,
    output logic [XLEN-1:0] o_wd3,
    output logic [AW-1:0]   o_a1,
    output logic [AW-1:0]   o_a2,
    input  logic [XLEN-1:0] i_rd1,
    input  logic [XLEN-1:0] i_rd2
);

    bist_state_t     r_state, w_state_nxt;
    logic [AW-1:0]   r_idx, w_idx_nxt;
    logic [AW-1:0]   r_fail_addr;
    logic [XLEN-1:0] r_fail_data;

    logic w_wr, w_rd, w_pat, w_last, w_idle, w_clear;
    logic w_mis1, w_mis2;

    assign w_wr    = (r_state == S_WR0) || (r_state == S_WR1);
    assign w_rd    = (r_state == S_RD0) || (r_state == S_RD1);
    assign w_pat   = (r_state == S_WR1) || (r_state == S_RD1);
    assign w_last  = &r_idx;
    assign w_idle  = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL);
    assign w_clear = w_idle && i_start;

    // Port 2 walks the address space backwards so both ports see every entry.
    assign w_mis1 = w_rd && (i_rd1 != bist_expect(w_pat, r_idx));
    assign w_mis2 = w_rd && (i_rd2 != bist_expect(w_pat, ~r_idx));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (i_start) begin
                    w_state_nxt = S_WR0;
                    w_idx_nxt   = AW'(1);
                end
            end
            S_WR0, S_WR1: begin
                if (w_last) begin
                    w_state_nxt = (r_state == S_WR0) ? S_RD0 : S_RD1;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            S_RD0, S_RD1: begin
                if (w_mis1 || w_mis2) begin
                    w_state_nxt = S_FAIL;
                end else if (w_last) begin
                    w_state_nxt = (r_state == S_RD0) ? S_WR1 : S_DONE;
                    w_idx_nxt   = (r_state == S_RD0) ? AW'(1) : r_idx;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_clear) begin
                r_fail_addr <= '0;
                r_fail_data <= '0;
            end else if (w_mis1) begin
                r_fail_addr <= r_idx;
                r_fail_data <= i_rd1;
            end else if (w_mis2) begin
                r_fail_addr <= ~r_idx;
                r_fail_data <= i_rd2;
            end
        end
    end

    always_comb begin
        o_we3 = w_wr;
        o_a3  = w_wr ? r_idx : '0;
        o_wd3 = w_wr ? bist_pattern(w_pat, r_idx) : '0;
        o_a1  = w_rd ? r_idx : '0;
        o_a2  = w_rd ? ~r_idx : '0;
    end

    assign o_busy      = w_wr || w_rd;
    assign o_done      = (r_state == S_DONE) || (r_state == S_FAIL);
    assign o_pass      = (r_state == S_DONE);
    assign o_fail      = (r_state == S_FAIL);
    assign o_fail_addr = r_fail_addr;
    assign o_fail_data = r_fail_data;

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Bench: BIST controller driving a behavioural 32x32 regfile with an XOR
// fault-injection layer on both read ports; results scored against a walk-through model.
module tb_regfile_bist_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, arm;
    logic        busy, done, pass, fail, we3;
    logic [4:0]  fail_addr, a3, a1, a2;
    logic [31:0] fail_data, wd3, rd1, rd2;

    always #5 clk = ~clk;

    regfile_bist_ctrl dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_fail(fail),
        .o_fail_addr(fail_addr), .o_fail_data(fail_data),
        .o_we3(we3), .o_a3(a3), .o_wd3(wd3), .o_a1(a1), .o_a2(a2),
        .i_rd1(rd1), .i_rd2(rd2)
    );

    logic [31:0] rf [32];
    logic        x0_written = 1'b0;
    int          cyc = 0;

    // Fault slots: XOR mask on a port when it reads f_addr during pass f_pass.
    logic        f1_en, f2_en, f1_pass, f2_pass;
    logic [4:0]  f1_addr, f2_addr;
    logic [31:0] f1_mask, f2_mask;

    initial for (int i = 0; i < 32; i++) rf[i] = '0;

    always @(posedge clk) begin
        if (we3 && a3 != 5'd0) rf[a3] <= wd3;
        if (we3 && a3 == 5'd0) x0_written <= 1'b1;
        if (start && arm) cyc <= 1;
        else              cyc <= cyc + 1;
    end

    function automatic bit in_rd(input logic p, input int c);
        return p ? (c >= 95 && c <= 126) : (c >= 32 && c <= 63);
    endfunction

    always_comb begin
        rd1 = (a1 == 5'd0) ? 32'd0 : rf[a1];
        rd2 = (a2 == 5'd0) ? 32'd0 : rf[a2];
        if (f1_en && a1 == f1_addr && in_rd(f1_pass, cyc)) rd1 = rd1 ^ f1_mask;
        if (f2_en && a2 == f2_addr && in_rd(f2_pass, cyc)) rd2 = rd2 ^ f2_mask;
    end

    typedef struct {
        int          cyc;
        bit          fail;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;

    function automatic logic [31:0] ref_val(input int p, input int i);
        logic [31:0] v;
        v = 32'hA5A5_A500 + i;
        if (i == 0) return 32'd0;
        return (p == 0) ? v : 32'hFFFF_FFFF - v;
    endfunction

    // Walk both passes entry by entry and report the first mismatch the test would see.
    function automatic exp_t model();
        exp_t        e;
        int          j;
        logic [31:0] x1, x2, v1, v2;
        e.cyc = 127; e.fail = 1'b0; e.addr = '0; e.data = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 32; i++) begin
                j  = 31 - i;
                x1 = ref_val(p, i);
                x2 = ref_val(p, j);
                v1 = x1; v2 = x2;
                if (f1_en && int'(f1_addr) == i && int'(f1_pass) == p) v1 = v1 ^ f1_mask;
                if (f2_en && int'(f2_addr) == j && int'(f2_pass) == p) v2 = v2 ^ f2_mask;
                if (v1 != x1 || v2 != x2) begin
                    e.cyc  = ((p == 0) ? 32 : 95) + i + 1;
                    e.fail = 1'b1;
                    e.addr = (v1 != x1) ? 5'(i) : 5'(j);
                    e.data = (v1 != x1) ? v1 : v2;
                    return e;
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: on each rising done, pop the oldest expectation and score it.
    initial begin
        logic prev_done;
        int   busy_cnt;
        exp_t e;
        prev_done = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (cyc == 1) busy_cnt = 0;
            if (busy) busy_cnt++;
            if (done && !prev_done && !reset) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_cycles", busy_cnt, e.cyc - 1);
                    chk("pass", {31'd0, pass}, {31'd0, !e.fail});
                    chk("fail", {31'd0, fail}, {31'd0, e.fail});
                    chk("fail_addr", {27'd0, fail_addr}, {27'd0, e.addr});
                    chk("fail_data", fail_data, e.data);
                end
            end
            prev_done = done;
        end
    end

    task automatic no_faults();
        f1_en = 0; f2_en = 0; f1_pass = 0; f2_pass = 0;
        f1_addr = '0; f2_addr = '0; f1_mask = '0; f2_mask = '0;
    endtask

    task automatic go(input bit push);
        @(negedge clk);
        start = 1'b1; arm = 1'b1;
        if (push) q.push_back(model());
        @(negedge clk);
        start = 1'b0; arm = 1'b0;
    endtask

    task automatic wait_scored();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout actual=%0d expected=0 pending", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc != c && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (cyc != c) begin
            total++; bad++;
            $display("FAIL wait_cycle actual=%0d expected=%0d", cyc, c);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {29'd0, done, pass, fail}, 32'd0);
        chk({tag, "_faddr"}, {27'd0, fail_addr}, 32'd0);
        chk({tag, "_fdata"}, fail_data, 32'd0);
        chk({tag, "_wr"}, {26'd0, we3, a3}, 32'd0);
        chk({tag, "_wd3"}, wd3, 32'd0);
        chk({tag, "_rdaddr"}, {22'd0, a1, a2}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; arm = 1'b0;
        no_faults();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // Clean run; the final image of x5 holds pattern 1.
        go(1'b1);
        chk("run_busy_c1", {31'd0, busy}, 32'd1);
        wait_scored();
        chk("x5_final", rf[5], 32'h5A5A_5AFA);

        // Stuck-at-1 on rd1 bit 3 reading x7 in pass 0; start issued from DONE.
        f1_en = 1; f1_addr = 5'd7; f1_pass = 0; f1_mask = 32'h8;
        go(1'b1);
        chk("restart_clears_pass", {30'd0, done, pass}, 32'd0);
        wait_scored();

        // rd2 of x0 forced to 1; start issued from FAIL clears latched result.
        no_faults();
        f2_en = 1; f2_addr = 5'd0; f2_pass = 0; f2_mask = 32'h1;
        go(1'b1);
        chk("restart_clears_fail", {30'd0, done, fail}, 32'd0);
        chk("restart_clears_faddr", {27'd0, fail_addr}, 32'd0);
        chk("restart_clears_fdata", fail_data, 32'd0);
        wait_scored();

        // Both ports mismatch at idx 2: port 1 wins.
        no_faults();
        f1_en = 1; f1_addr = 5'd2;  f1_mask = $urandom_range(1, 32'hFFFF);
        f2_en = 1; f2_addr = 5'd29; f2_mask = $urandom_range(1, 32'hFFFF);
        f1_pass = 1'($urandom_range(0, 1)); f2_pass = f1_pass;
        go(1'b1);
        wait_scored();

        // Reset mid-run, then a clean full run.
        no_faults();
        go(1'b0);
        wait_cyc(50);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        reset = 1'b0;
        go(1'b1);
        wait_scored();

        // A start during a run is ignored; a start in DONE reruns.
        go(1'b1);
        wait_cyc(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_busy", {31'd0, busy}, 32'd1);
        wait_scored();
        chk("done_before_rerun", {30'd0, done, pass}, 32'd3);
        go(1'b1);
        chk("rerun_pass_clear", {30'd0, pass, busy}, 32'd1);
        wait_scored();

        // Randomized fault campaigns.
        for (int r = 0; r < 8; r++) begin
            f1_en   = 1'($urandom_range(0, 1));
            f2_en   = 1'($urandom_range(0, 1));
            f1_addr = 5'($urandom_range(0, 31));
            f2_addr = 5'($urandom_range(0, 31));
            f1_pass = 1'($urandom_range(0, 1));
            f2_pass = 1'($urandom_range(0, 1));
            f1_mask = 32'(1) << $urandom_range(0, 31);
            f2_mask = $urandom();
            go(1'b1);
            wait_scored();
        end

        chk("x0_never_written", {31'd0, x0_written}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_bist_ctrl.md
# regfile_bist_ctrl

Built-in self-test sequencer for the 32×32 register file. On a `start` pulse it takes over the register file's write port (`we3`, `a3`, `wd3`) and both read ports (`a1`/`rd1`, `a2`/`rd2`). It writes two complementary address-tagged patterns and reads every register back on both ports, then reports pass or fail with the first failing address and the data observed there. It sits between the board-level input demux and the regfile, and drives the regfile whenever `busy` is high.

## Interface
- `XLEN`, 32, data width.
- `AW`, 5, address width (32 registers, x0 hardwired to zero).
- `clk`  in  1  system clock; rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `start`  in  1  single-cycle request to run the test.
- `busy`  out  1  test in progress; the controller owns the regfile ports.
- `done`  out  1  test finished; sticky until the next `start` or `reset`.
- `pass`  out  1  `done` and no mismatch found.
- `fail`  out  1  `done` and a mismatch was found.
- `fail_addr`  out  AW  address of the first mismatch.
- `fail_data`  out  XLEN  `rd` value read at that first mismatch.
- `we3`  out  1  regfile write enable.
- `a3`  out  AW  regfile write address.
- `wd3`  out  XLEN  regfile write data.
- `a1`, `a2`  out  AW  regfile read addresses.
- `rd1`, `rd2`  in  XLEN  regfile read data; combinational from `a1`/`a2`.

## Operation
- States: IDLE, WR0, RD0, WR1, RD1, DONE, FAIL.
- Counter `idx` is AW bits wide.
- Pattern function:
  - P0(i) = PAT_BASE | i, where PAT_BASE = 32'hA5A5_A500.
  - P1(i) = ~P0(i).
- Expected read value:
  - E(p,0) = 0.
  - E(p,i) = Pp(i) for i ≠ 0.
- IDLE, DONE or FAIL, with `start`=1: go to WR0 with `idx`=1; clear `done`, `pass`, `fail`, `fail_addr` and `fail_data`.
- WRn:
  - Drive `we3`=1, `a3`=`idx`, `wd3`=Pn(`idx`).
  - `idx` runs 1..31.
  - At `idx`=31, go to RDn with `idx`=0.
  - x0 is never written.
- RDn:
  - Drive `a1`=`idx` and `a2`=31−`idx` (bitwise ~`idx`).
  - Compare `rd1` against E(n,`a1`) and `rd2` against E(n,`a2`).
  - On any mismatch, go to FAIL and latch `fail_addr` and `fail_data` from the failing port. If both ports mismatch in the same cycle, port 1 takes priority.
  - With no mismatch at `idx`=31: RD0 goes to WR1 with `idx`=1; RD1 goes to DONE.
- DONE: `done`=1, `pass`=1.
- FAIL: `done`=1, `fail`=1.
- `start` during WR/RD is ignored.
- Outside WR states: `we3`=0, `a3`=0, `wd3`=0.
- Outside RD states: `a1`=0, `a2`=0.
- `busy`=1 exactly in the WR0, RD0, WR1 and RD1 states.
- Reset mid-test: back to IDLE next edge, `we3`=0 immediately after that edge; regfile contents are undefined.

## Timing
- All state, `idx` and result registers update on the rising edge of `clk`.
- Port outputs are Moore: decoded from state and `idx`, valid for the whole cycle.
- Regfile writes commit at the end of the WR cycle. Read checks compare combinationally and are registered at the cycle-end edge.
- Reset values: state=IDLE, `idx`=0, and all outputs 0.
- Latency counts cycles from the edge that samples `start`:
  - WR0 occupies cycles 1–31, RD0 cycles 32–63, WR1 cycles 64–94, RD1 cycles 95–126.
  - `done`=1 from cycle 127.
- Failure latency: `fail`=1 in the cycle after the mismatching RD cycle.
- `idx` never wraps; a terminal count of 31 forces the state transition.

## Structure
- Package `regfile_bist_pkg` holds:
  - the state enum `bist_state_t`,
  - PAT_BASE,
  - function `bist_pattern(pat, idx)`,
  - function `bist_expect(pat, idx)` (returns 0 for idx 0).
- Single module with no sub-module; the comparator is two inline equality checks.
- Bench instantiates `regfile_bist_ctrl` together with the existing regfile, plus a fault-injection wrapper on `rd1`/`rd2`.

## Test plan
- Reset, then `start` for 1 cycle with a good regfile:
  - `busy`=1 for exactly 126 cycles.
  - `done`=1, `pass`=1, `fail`=0 from cycle 127.
  - Final register x5 = 32'h5A5A_5AFA.
- Inject a stuck-at-1 on `rd1` bit 3 when `a1`=7 in pass 0:
  - `fail`=1 at cycle 40.
  - `fail_addr`=7, `fail_data`=32'hA5A5_A50F.
- Force `rd2` of x0 to 32'h1 (read at RD0, `idx`=31):
  - FAIL with `fail_addr`=0, `fail_data`=32'h1.
- Make both ports mismatch in the same cycle (`idx`=2): latched `fail_addr`=2 (port 1 priority), not 29.
- Assert `reset` at cycle 50, then `start` again: IDLE with all outputs 0, then a full 126-cycle run ending in `pass`=1.
- Pulse `start` at cycle 10 during a run: no restart, and `done` still arrives at cycle 127; a `start` in DONE clears `pass` and reruns.
